// File: rtl/madd_pkg.sv
// ---------------------------------------------------------------------------
// madd_pkg
// Shared definitions for the DMADD sequencer slice:
//   - seq_state_e  : sequencer state encoding (IDLE, LOAD, RUN, CAPT, DONE)
//   - INSN_*       : DMADD opcode encodings carried on madd_insn
//   - DEF_*        : default widths / run window used by madd_sequencer
//   - sat_inc16    : saturating 16-bit increment for the completed-op counter
// ---------------------------------------------------------------------------
package madd_pkg;

    // Default datapath geometry of the DMADD instance.
    localparam int DEF_IDX_W      = 4;
    localparam int DEF_DAT_W      = 4;
    localparam int DEF_RES_W      = 16;
    localparam int DEF_RUN_CYCLES = 4;
    localparam int OPCNT_W        = 16;

    // DMADD opcode encodings. NOP is also what madd_insn rests at while idle.
    localparam logic [1:0] INSN_NOP  = 2'd0;
    localparam logic [1:0] INSN_ADD  = 2'd1;
    localparam logic [1:0] INSN_MUL  = 2'd2;
    localparam logic [1:0] INSN_MADD = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        CAPT = 3'd3,
        DONE = 3'd4
    } seq_state_e;

    // Counts up and sticks at all-ones instead of wrapping back to zero.
    function automatic logic [OPCNT_W-1:0] sat_inc16(input logic [OPCNT_W-1:0] v);
        return (v == {OPCNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/madd_seq_ctr.sv
// ---------------------------------------------------------------------------
// madd_seq_ctr
// Loadable down-counter with a zero flag. Used twice by madd_sequencer: once
// to count the remaining operand nibbles and once to time the run window.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_val (has priority over dec)
//   load_val    : value to load
//   dec         : decrement by one; holds at zero instead of wrapping
//   zero        : high while the count is zero
// ---------------------------------------------------------------------------
module madd_seq_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: a load wins over a decrement, and the count never underflows.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/madd_sequencer.sv
// ---------------------------------------------------------------------------
// madd_sequencer
// Sequences the DMADD multiply-add datapath from a host command/data stream.
// One descriptor (opcode + nibble count) is accepted, the nibbles are
// streamed into DMADD's indexed operand store, run is held for RUN_CYCLES
// cycles, the result is captured and then offered on a valid/ready port.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   abort                 synchronous abort back to IDLE from any state
//   cmd_valid/cmd_ready   descriptor handshake; cmd_insn, cmd_len (0 = 2**IDX_W)
//   dat_valid/dat_ready   operand nibble handshake; dat_nib
//   res_valid/res_ready   result handshake; res_data
//   busy                  high in every state except IDLE
//   op_count              completed-operation counter
//   madd_load/run/insn/index/data   registered drive into DMADD
//   madd_out              result from DMADD
//
// Build option:
//   MADD_SEQ_OPCOUNT_EN   when defined, op_count counts result handshakes
//                         (saturating, cleared only by reset); otherwise
//                         op_count is tied to zero and no counter exists.
// ---------------------------------------------------------------------------
module madd_sequencer
    import madd_pkg::*;
#(
    parameter int IDX_W      = DEF_IDX_W,
    parameter int DAT_W      = DEF_DAT_W,
    parameter int RES_W      = DEF_RES_W,
    parameter int RUN_CYCLES = DEF_RUN_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_insn,
    input  logic [IDX_W-1:0]   cmd_len,
    input  logic               dat_valid,
    output logic               dat_ready,
    input  logic [DAT_W-1:0]   dat_nib,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [RES_W-1:0]   res_data,
    output logic               busy,
    output logic [OPCNT_W-1:0] op_count,
    output logic               madd_load,
    output logic               madd_run,
    output logic [1:0]         madd_insn,
    output logic [IDX_W-1:0]   madd_index,
    output logic [DAT_W-1:0]   madd_data,
    input  logic [RES_W-1:0]   madd_out
);

    localparam int RUN_W = $clog2(RUN_CYCLES + 1);

    seq_state_e         state_q, state_d;
    logic               madd_load_q, madd_load_d;
    logic               madd_run_q, madd_run_d;
    logic [1:0]         madd_insn_q, madd_insn_d;
    logic [IDX_W-1:0]   madd_index_q, madd_index_d;
    logic [DAT_W-1:0]   madd_data_q, madd_data_d;
    logic               res_valid_q, res_valid_d;
    logic [RES_W-1:0]   res_data_q, res_data_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic cmd_accept;
    logic dat_accept;
    logic last_nib;
    logic res_hs;
    logic nib_zero;
    logic run_zero;

    // Handshake decode. abort suppresses every acceptance in the same cycle,
    // so an in-flight nibble or result is simply dropped.
    assign cmd_ready  = (state_q == IDLE);
    assign dat_ready  = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign cmd_accept = cmd_ready && cmd_valid && !abort;
    assign dat_accept = dat_ready && dat_valid && !abort;
    assign last_nib   = dat_accept && nib_zero;
    assign res_hs     = (state_q == DONE) && res_valid_q && res_ready && !abort;

    // Remaining-nibble counter holds (len - 1); zero marks the final nibble.
    // len = 0 wraps to all-ones, which is exactly 2**IDX_W nibbles.
    madd_seq_ctr #(
        .W (IDX_W)
    ) u_nib_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cmd_accept),
        .load_val (cmd_len - 1'b1),
        .dec      (dat_accept),
        .zero     (nib_zero)
    );

    // Run-window counter: loaded as the final nibble is taken, then counts
    // down once per RUN cycle. madd_run is requested while it is non-zero.
    madd_seq_ctr #(
        .W (RUN_W)
    ) u_run_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (last_nib),
        .load_val (RUN_W'(RUN_CYCLES)),
        .dec      (state_q == RUN),
        .zero     (run_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. RUN spans the final load-pulse cycle plus the
    // RUN_CYCLES cycles madd_run is high, so CAPT is the first cycle with
    // madd_run low again.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cmd_accept) state_d = LOAD;
            LOAD: if (last_nib)   state_d = RUN;
            RUN:  if (run_zero)   state_d = CAPT;
            CAPT:                 state_d = DONE;
            DONE: if (res_hs)     state_d = IDLE;
            default:              state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Output / datapath next values. Every madd_* output is a flop, so the
    // load pulse for a nibble appears the cycle after it is accepted.
    always_comb begin
        madd_load_d  = 1'b0;
        madd_run_d   = 1'b0;
        madd_insn_d  = madd_insn_q;
        madd_index_d = madd_index_q;
        madd_data_d  = madd_data_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        idx_d        = idx_q;

        unique case (state_q)
            IDLE: begin
                madd_insn_d = INSN_NOP;
                if (cmd_accept) begin
                    madd_insn_d = cmd_insn;
                    idx_d       = '0;
                end
            end
            LOAD: begin
                if (dat_accept) begin
                    madd_load_d  = 1'b1;
                    madd_index_d = idx_q;
                    madd_data_d  = dat_nib;
                    // Stop advancing on the last nibble so the index never wraps.
                    if (!nib_zero) begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RUN: begin
                madd_run_d = !run_zero;
            end
            CAPT: begin
                res_data_d  = madd_out;
                res_valid_d = 1'b1;
                madd_insn_d = INSN_NOP;
            end
            DONE: begin
                if (res_hs) begin
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                madd_insn_d = INSN_NOP;
            end
        endcase

        if (abort) begin
            madd_load_d = 1'b0;
            madd_run_d  = 1'b0;
            res_valid_d = 1'b0;
            madd_insn_d = INSN_NOP;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            madd_load_q  <= 1'b0;
            madd_run_q   <= 1'b0;
            madd_insn_q  <= INSN_NOP;
            madd_index_q <= '0;
            madd_data_q  <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            idx_q        <= '0;
        end else begin
            madd_load_q  <= madd_load_d;
            madd_run_q   <= madd_run_d;
            madd_insn_q  <= madd_insn_d;
            madd_index_q <= madd_index_d;
            madd_data_q  <= madd_data_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            idx_q        <= idx_d;
        end
    end

`ifdef MADD_SEQ_OPCOUNT_EN
    logic [OPCNT_W-1:0] op_count_q, op_count_d;

    // Completed-operation counter: one step per result handshake, sticking
    // at all-ones. Aborted operations never reach the handshake.
    always_comb begin
        op_count_d = op_count_q;
        if (res_hs) begin
            op_count_d = sat_inc16(op_count_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = '0;
`endif

    assign madd_load  = madd_load_q;
    assign madd_run   = madd_run_q;
    assign madd_insn  = madd_insn_q;
    assign madd_index = madd_index_q;
    assign madd_data  = madd_data_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;

endmodule

// File: tb/tb_madd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_madd_sequencer
// Self-checking bench for madd_sequencer. Expected operand-store writes are
// queued as nibbles are accepted and popped when madd_load pulses; expected
// results are queued per command and popped when res_valid appears.
// Honours MADD_SEQ_OPCOUNT_EN for the op_count expectation.
// ---------------------------------------------------------------------------
module tb_madd_sequencer;
    import madd_pkg::*;

    localparam int IDX_W      = 4;
    localparam int DAT_W      = 4;
    localparam int RES_W      = 16;
    localparam int RUN_CYCLES = 4;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [DAT_W-1:0] dat;
    } load_t;

    logic             clk;
    logic             rst_n;
    logic             abort;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_insn;
    logic [IDX_W-1:0] cmd_len;
    logic             dat_valid;
    logic             dat_ready;
    logic [DAT_W-1:0] dat_nib;
    logic             res_valid;
    logic             res_ready;
    logic [RES_W-1:0] res_data;
    logic             busy;
    logic [15:0]      op_count;
    logic             madd_load;
    logic             madd_run;
    logic [1:0]       madd_insn;
    logic [IDX_W-1:0] madd_index;
    logic [DAT_W-1:0] madd_data;
    logic [RES_W-1:0] madd_out;

    load_t            load_q[$];
    logic [RES_W-1:0] res_q[$];
    logic [DAT_W-1:0] nib_tbl[16];

    int checks    = 0;
    int errors    = 0;
    int load_seen = 0;
    int ops_done  = 0;

    madd_sequencer #(
        .IDX_W      (IDX_W),
        .DAT_W      (DAT_W),
        .RES_W      (RES_W),
        .RUN_CYCLES (RUN_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort      (abort),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_insn   (cmd_insn),
        .cmd_len    (cmd_len),
        .dat_valid  (dat_valid),
        .dat_ready  (dat_ready),
        .dat_nib    (dat_nib),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .op_count   (op_count),
        .madd_load  (madd_load),
        .madd_run   (madd_run),
        .madd_insn  (madd_insn),
        .madd_index (madd_index),
        .madd_data  (madd_data),
        .madd_out   (madd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard for operand-store writes: every load pulse must match the
    // oldest accepted nibble, and no pulse may appear without one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && madd_load === 1'b1) begin
            checks++;
            if (load_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL load_unexpected: got index %0d data %h, required no load pulse",
                         madd_index, madd_data);
            end else begin
                load_t e;
                e = load_q.pop_front();
                load_seen++;
                if (madd_index !== e.idx || madd_data !== e.dat) begin
                    errors++;
                    $display("[TB] FAIL load_pulse: got index %0d data %h, required index %0d data %h",
                             madd_index, madd_data, e.idx, e.dat);
                end
            end
        end
    end

    task automatic send_cmd(input logic [1:0] insn, input logic [IDX_W-1:0] len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_insn  = insn;
        cmd_len   = len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Streams nib_tbl[0..n-1]; returns on the negedge of the last load pulse.
    task automatic drive_nibbles(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int g;
            load_t e;
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            if (g > 0) begin
                @(negedge clk);
                dat_valid = 1'b0;
                repeat (g - 1) @(negedge clk);
            end
            @(negedge clk);
            dat_valid = 1'b1;
            dat_nib   = nib_tbl[i];
            @(posedge clk);
            #1;
            e.idx = IDX_W'(i);
            e.dat = nib_tbl[i];
            load_q.push_back(e);
        end
        @(negedge clk);
        dat_valid = 1'b0;
    endtask

    // delay: negedges until madd_run first seen high; width: cycles high.
    // Returns on the first negedge with madd_run low after the window.
    task automatic measure_run(output int delay, output int width);
        delay = 0;
        width = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (madd_run === 1'b1) begin
                if (width == 0) delay = k;
                width++;
            end else if (width > 0) begin
                break;
            end
        end
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (res_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_handshake();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        ops_done++;
    endtask

    task automatic test_reset();
        bit seen;
        cmd_valid = 1'b0; cmd_insn = 2'd0; cmd_len = '0;
        dat_valid = 1'b0; dat_nib = '0; res_ready = 1'b0;
        abort = 1'b0; madd_out = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || dat_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshake: got cmd_ready %b dat_ready %b busy %b, required 1 0 0",
                     cmd_ready, dat_ready, busy);
        end
        checks++;
        if ({madd_load, madd_run, madd_insn, madd_index, madd_data} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_madd: got load %b run %b insn %0d index %0d data %h, required all 0",
                     madd_load, madd_run, madd_insn, madd_index, madd_data);
        end
        checks++;
        if (res_valid !== 1'b0 || res_data !== '0 || op_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_result: got res_valid %b res_data %h op_count %0d, required 0 0000 0",
                     res_valid, res_data, op_count);
        end

        // Asynchronous reset while madd_run is high.
        madd_out   = 16'hDEAD;
        nib_tbl[0] = 4'h3;
        send_cmd(INSN_ADD, 4'd1);
        drive_nibbles(1, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (madd_run === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL reset_reach_run: got madd_run low for 10 cycles, required high");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (madd_run !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_run: got run %b res_valid %b cmd_ready %b busy %b, required 0 0 1 0",
                     madd_run, res_valid, cmd_ready, busy);
        end
        load_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || madd_run !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL reset_no_partial: got res_valid or madd_run high after reset, required both low");
        end
    endtask

    task automatic test_basic();
        int d, w, base;
        bit ok;
        logic [RES_W-1:0] exp;
        madd_out   = 16'h1234;
        nib_tbl[0] = 4'h5;
        nib_tbl[1] = 4'hA;
        nib_tbl[2] = 4'hF;
        base = load_seen;
        send_cmd(INSN_MUL, 4'd3);
        res_q.push_back(16'h1234);
        @(negedge clk);
        checks++;
        if (madd_insn !== INSN_MUL || dat_ready !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_load_state: got insn %0d dat_ready %b cmd_ready %b busy %b, required 2 1 0 1",
                     madd_insn, dat_ready, cmd_ready, busy);
        end
        drive_nibbles(3, 1'b0);
        checks++;
        if (madd_run !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_run_early: got madd_run %b with last load pulse, required 0", madd_run);
        end
        measure_run(d, w);
        checks++;
        if (d !== 1 || w !== RUN_CYCLES) begin
            errors++;
            $display("[TB] FAIL basic_run_window: got delay %0d width %0d, required delay 1 width %0d",
                     d, w, RUN_CYCLES);
        end
        checks++;
        if (res_valid !== 1'b0 || madd_insn !== INSN_MUL) begin
            errors++;
            $display("[TB] FAIL basic_capt: got res_valid %b insn %0d in capture cycle, required 0 2",
                     res_valid, madd_insn);
        end
        checks++;
        if (load_seen - base !== 3) begin
            errors++;
            $display("[TB] FAIL basic_load_count: got %0d load pulses, required 3", load_seen - base);
        end
        wait_res(ok);
        exp = res_q.pop_front();
        checks++;
        if (!ok || res_data !== exp) begin
            errors++;
            $display("[TB] FAIL basic_result: got valid %b data %h, required valid 1 data %h", ok, res_data, exp);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== exp) begin
            errors++;
            $display("[TB] FAIL basic_result_hold: got valid %b data %h, required 1 %h", res_valid, res_data, exp);
        end
        do_handshake();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || madd_insn !== INSN_NOP) begin
            errors++;
            $display("[TB] FAIL basic_to_idle: got res_valid %b cmd_ready %b insn %0d, required 0 1 0",
                     res_valid, cmd_ready, madd_insn);
        end
    endtask

    task automatic test_len16_gaps();
        int d, w, base;
        bit ok;
        logic [RES_W-1:0] exp;
        madd_out = 16'h0F5A;
        for (int i = 0; i < 16; i++) nib_tbl[i] = DAT_W'($urandom);
        base = load_seen;
        send_cmd(INSN_MADD, 4'd0);
        res_q.push_back(16'h0F5A);
        drive_nibbles(16, 1'b1);
        measure_run(d, w);
        checks++;
        if (d !== 1 || w !== RUN_CYCLES) begin
            errors++;
            $display("[TB] FAIL len16_run_window: got delay %0d width %0d, required delay 1 width %0d",
                     d, w, RUN_CYCLES);
        end
        checks++;
        if (load_seen - base !== 16 || load_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL len16_load_count: got %0d pulses %0d pending, required 16 pulses 0 pending",
                     load_seen - base, load_q.size());
        end
        wait_res(ok);
        exp = res_q.pop_front();
        checks++;
        if (!ok || res_data !== exp) begin
            errors++;
            $display("[TB] FAIL len16_result: got valid %b data %h, required valid 1 data %h", ok, res_data, exp);
        end
        do_handshake();
    endtask

    task automatic test_backpressure();
        int d, w;
        bit ok;
        logic [RES_W-1:0] exp;
        madd_out   = 16'hBEEF;
        nib_tbl[0] = 4'h1;
        nib_tbl[1] = 4'h2;
        send_cmd(INSN_ADD, 4'd2);
        res_q.push_back(16'hBEEF);
        drive_nibbles(2, 1'b0);
        measure_run(d, w);
        wait_res(ok);
        exp = res_q.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL bp_result_valid: got res_valid %b after 20 cycles, required 1", res_valid);
        end
        madd_out = 16'h0000;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp || cmd_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d: got valid %b data %h cmd_ready %b, required 1 %h 0",
                         k, res_valid, res_data, cmd_ready, exp);
            end
            @(negedge clk);
        end
        do_handshake();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_release: got res_valid %b cmd_ready %b busy %b, required 0 1 0",
                     res_valid, cmd_ready, busy);
        end
    endtask

    task automatic test_abort();
        bit run_seen;
        logic [15:0] exp_cnt;
`ifdef MADD_SEQ_OPCOUNT_EN
        exp_cnt = 16'(ops_done);
`else
        exp_cnt = 16'd0;
`endif
        madd_out   = 16'h5555;
        nib_tbl[0] = 4'h9;
        nib_tbl[1] = 4'h6;
        send_cmd(INSN_ADD, 4'd4);
        drive_nibbles(2, 1'b0);
        abort     = 1'b1;
        dat_valid = 1'b1;
        dat_nib   = 4'h7;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        dat_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || madd_load !== 1'b0 || madd_run !== 1'b0 ||
            res_valid !== 1'b0 || madd_insn !== INSN_NOP) begin
            errors++;
            $display("[TB] FAIL abort_idle: got busy %b cmd_ready %b load %b run %b res_valid %b insn %0d, required 0 1 0 0 0 0",
                     busy, cmd_ready, madd_load, madd_run, res_valid, madd_insn);
        end
        run_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (madd_run !== 1'b0 || res_valid !== 1'b0) run_seen = 1'b1;
        end
        checks++;
        if (run_seen) begin
            errors++;
            $display("[TB] FAIL abort_no_run: got madd_run or res_valid high after abort, required both low");
        end
        checks++;
        if (op_count !== exp_cnt) begin
            errors++;
            $display("[TB] FAIL abort_op_count: got %0d, required %0d", op_count, exp_cnt);
        end
    endtask

    task automatic test_opcount();
        logic [15:0] exp_cnt;
`ifdef MADD_SEQ_OPCOUNT_EN
        exp_cnt = 16'(ops_done);
`else
        exp_cnt = 16'd0;
`endif
        @(negedge clk);
        checks++;
        if (op_count !== exp_cnt) begin
            errors++;
            $display("[TB] FAIL op_count: got %0d, required %0d", op_count, exp_cnt);
        end
        checks++;
        if (load_q.size() != 0 || res_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d loads %0d results pending, required 0 0",
                     load_q.size(), res_q.size());
        end
    endtask

    initial begin
        $display("[TB] starting madd_sequencer bench");
        test_reset();
        test_basic();
        test_len16_gaps();
        test_backpressure();
        test_abort();
        test_opcount();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
